trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_pkg.sv | 35 +++
 rtl/trap_irq_arb.sv | 37 +++
 rtl/trap_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants and state encoding for the trap sequencer.
// CSR addresses, mstatus bit positions, cause codes, FSM states.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [3:0] EXC_ILLEGAL  = 4'd2;
    localparam logic [3:0] EXC_EBREAK   = 4'd3;
    localparam logic [3:0] EXC_LD_MISAL = 4'd4;
    localparam logic [3:0] EXC_ST_MISAL = 4'd6;
    localparam logic [3:0] EXC_ECALL_M  = 4'd11;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MTVAL,
        S_W_MSTAT,
        S_M_MSTAT,
        S_REDIR
    } trap_state_e;

endpackage

// File: rtl/trap_irq_arb.sv
// Interrupt masking and fixed-priority encode (MEI > MSI > MTI).
// Ports: mstatus_mie, mie_* enables, irq_* lines -> irq_pending, irq_code.
module trap_irq_arb
    import trap_ctrl_pkg::*;
(
    input  logic       mstatus_mie,
    input  logic       mie_ext,
    input  logic       mie_sw,
    input  logic       mie_timer,
    input  logic       irq_ext,
    input  logic       irq_sw,
    input  logic       irq_timer,
    output logic       irq_pending,
    output logic [3:0] irq_code
);

    logic ext_p;
    logic sw_p;
    logic tm_p;

    assign ext_p = irq_ext & mie_ext;
    assign sw_p  = irq_sw & mie_sw;
    assign tm_p  = irq_timer & mie_timer;

    assign irq_pending = mstatus_mie & (ext_p | sw_p | tm_p);

    always_comb begin
        irq_code = '0;
        if (ext_p)
            irq_code = IRQ_MEI;
        else if (sw_p)
            irq_code = IRQ_MSI;
        else if (tm_p)
            irq_code = IRQ_MTI;
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: writes mepc/mcause/mtval/mstatus, then redirects fetch.
// Ports: exception/mret/irq requests in, CSR write port out, stall/flush/redirect out.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int VEC_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] int_pc,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            irq_timer,
    input  logic [XLEN-1:0] csr_mstatus,
    input  logic [XLEN-1:0] csr_mie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic            csr_wack,
    output logic            trap_busy,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_e state_q, state_n;

    logic [XLEN-1:0] epc_q, cause_q, tval_q;
    logic [3:0]      code_q;
    logic            is_int_q, is_mret_q;

    logic            we_n;
    logic [11:0]     waddr_n;
    logic [XLEN-1:0] wdata_n;

    logic            irq_pending;
    logic [3:0]      irq_code;
    logic            idle, accept;
    logic            take_exc, take_mret, take_irq;
    logic [XLEN-1:0] cap_epc, cap_cause, cap_tval;
    logic [XLEN-1:0] base, tgt;
    logic            vec;
    logic            unused_ok;

    function automatic logic [XLEN-1:0] trap_mstat(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] m;
        m = s;
        m[MSTATUS_MPIE] = s[MSTATUS_MIE];
        m[MSTATUS_MIE]  = 1'b0;
        m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return m;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstat(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] m;
        m = s;
        m[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        m[MSTATUS_MPIE] = 1'b1;
        m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return m;
    endfunction

    trap_irq_arb u_arb (
        .mstatus_mie (csr_mstatus[MSTATUS_MIE]),
        .mie_ext     (csr_mie[11]),
        .mie_sw      (csr_mie[3]),
        .mie_timer   (csr_mie[7]),
        .irq_ext     (irq_ext),
        .irq_sw      (irq_sw),
        .irq_timer   (irq_timer),
        .irq_pending (irq_pending),
        .irq_code    (irq_code)
    );

    assign idle      = (state_q == S_IDLE);
    assign take_exc  = idle & exc_valid;
    assign take_mret = idle & ~exc_valid & mret_valid;
    assign take_irq  = idle & ~exc_valid & ~mret_valid & irq_pending;
    assign accept    = take_exc | take_mret | take_irq;

    assign cap_epc   = take_exc ? exc_pc : int_pc;
    assign cap_cause = take_exc ? {1'b0, {(XLEN-5){1'b0}}, exc_cause}
                                : {1'b1, {(XLEN-5){1'b0}}, irq_code};
    assign cap_tval  = take_exc ? exc_tval : '0;

    assign trap_busy = accept | ~idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (take_exc | take_irq)
                    state_n = S_W_MEPC;
                else if (take_mret)
                    state_n = S_M_MSTAT;
            end
            S_W_MEPC:   if (csr_wack) state_n = S_W_MCAUSE;
            S_W_MCAUSE: if (csr_wack) state_n = S_W_MTVAL;
            S_W_MTVAL:  if (csr_wack) state_n = S_W_MSTAT;
            S_W_MSTAT:  if (csr_wack) state_n = S_REDIR;
            S_M_MSTAT:  if (csr_wack) state_n = S_REDIR;
            S_REDIR:    state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Write port is loaded only on state entry so it stays put while
    // the csr block stalls the ack.
    always_comb begin
        we_n    = 1'b0;
        waddr_n = csr_waddr;
        wdata_n = csr_wdata;
        unique case (state_n)
            S_W_MEPC, S_W_MCAUSE, S_W_MTVAL,
            S_W_MSTAT, S_M_MSTAT: we_n = 1'b1;
            default:              we_n = 1'b0;
        endcase
        if (state_n != state_q) begin
            unique case (state_n)
                S_W_MEPC: begin
                    waddr_n = CSR_MEPC;
                    wdata_n = cap_epc;
                end
                S_W_MCAUSE: begin
                    waddr_n = CSR_MCAUSE;
                    wdata_n = cause_q;
                end
                S_W_MTVAL: begin
                    waddr_n = CSR_MTVAL;
                    wdata_n = tval_q;
                end
                S_W_MSTAT: begin
                    waddr_n = CSR_MSTATUS;
                    wdata_n = trap_mstat(csr_mstatus);
                end
                S_M_MSTAT: begin
                    waddr_n = CSR_MSTATUS;
                    wdata_n = mret_mstat(csr_mstatus);
                end
                default: begin
                    waddr_n = '0;
                    wdata_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_we         <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            epc_q          <= '0;
            cause_q        <= '0;
            tval_q         <= '0;
            code_q         <= '0;
            is_int_q       <= 1'b0;
            is_mret_q      <= 1'b0;
        end else begin
            csr_we         <= we_n;
            csr_waddr      <= waddr_n;
            csr_wdata      <= wdata_n;
            flush          <= accept;
            redirect_valid <= (state_n == S_REDIR);
            if (take_exc | take_irq) begin
                epc_q   <= cap_epc;
                cause_q <= cap_cause;
                tval_q  <= cap_tval;
                code_q  <= take_exc ? exc_cause : irq_code;
            end
            if (accept) begin
                is_int_q  <= take_irq;
                is_mret_q <= take_mret;
            end
        end
    end

    assign base = {csr_mtvec[XLEN-1:2], 2'b00};
    assign vec  = (VEC_EN != 0) && is_int_q && (csr_mtvec[1:0] == 2'b01);
    assign tgt  = vec ? base + XLEN'({code_q, 2'b00}) : base;

    // mret target reads mepc live in the redirect cycle.
    assign redirect_pc = !redirect_valid ? '0
                       : is_mret_q ? {csr_mepc[XLEN-1:1], 1'b0}
                       : tgt;

    assign unused_ok = ^{csr_mie[XLEN-1:12], csr_mie[10:8],
                         csr_mie[6:4], csr_mie[2:0],
                         csr_mepc[0], epc_q};

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: scoreboard of CSR writes and
// redirects plus per-scenario cycle timing checks.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        mret_valid;
    logic [31:0] int_pc;
    logic        irq_ext, irq_sw, irq_timer;
    logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wack;
    logic        trap_busy, flush, redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    logic [43:0] wr_q[$];
    logic [31:0] rd_q[$];

    trap_ctrl #(.XLEN(32), .VEC_EN(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .int_pc         (int_pc),
        .irq_ext        (irq_ext),
        .irq_sw         (irq_sw),
        .irq_timer      (irq_timer),
        .csr_mstatus    (csr_mstatus),
        .csr_mie        (csr_mie),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_wack       (csr_wack),
        .trap_busy      (trap_busy),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop on every accepted write and every redirect.
    always @(negedge clk) begin
        logic [43:0] ew;
        logic [31:0] er;
        if (!rst && csr_we && csr_wack) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL csr_write unexpected got addr=%h data=%h",
                         csr_waddr, csr_wdata);
            end else begin
                ew = wr_q.pop_front();
                if ({csr_waddr, csr_wdata} !== ew) begin
                    failures++;
                    $display("FAIL csr_write got addr=%h data=%h exp addr=%h data=%h",
                             csr_waddr, csr_wdata, ew[43:32], ew[31:0]);
                end
            end
        end
        if (!rst && redirect_valid) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL redirect unexpected got pc=%h", redirect_pc);
            end else begin
                er = rd_q.pop_front();
                if (redirect_pc !== er) begin
                    failures++;
                    $display("FAIL redirect_pc got=%h exp=%h", redirect_pc, er);
                end
            end
        end
    end

    task automatic idle_inputs();
        exc_valid  = 1'b0;
        exc_cause  = 4'd0;
        exc_pc     = 32'h0;
        exc_tval   = 32'h0;
        mret_valid = 1'b0;
        int_pc     = 32'h0;
        irq_ext    = 1'b0;
        irq_sw     = 1'b0;
        irq_timer  = 1'b0;
        csr_wack   = 1'b1;
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] mst,
                             input logic [31:0] rpc);
        wr_q.push_back({12'h341, epc});
        wr_q.push_back({12'h342, cause});
        wr_q.push_back({12'h343, tval});
        wr_q.push_back({12'h300, mst});
        rd_q.push_back(rpc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        csr_mstatus = 32'h0;
        csr_mie     = 32'h0;
        csr_mtvec   = 32'h0;
        csr_mepc    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({csr_we, trap_busy, flush, redirect_valid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {csr_we, trap_busy, flush, redirect_valid});
        end
        checks++;
        if ({csr_waddr, csr_wdata, redirect_pc} !== 76'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0",
                     {csr_waddr, csr_wdata, redirect_pc});
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_ecall();
        csr_mstatus = 32'h8;
        csr_mtvec   = 32'h8000_0000;
        push_trap(32'h8000_0100, 32'hB, 32'h0, 32'h1880, 32'h8000_0000);
        exc_valid = 1'b1;
        exc_cause = 4'd11;
        exc_pc    = 32'h8000_0100;
        exc_tval  = 32'h0;
        @(negedge clk);
        checks++;
        if (trap_busy !== 1'b1) begin
            failures++;
            $display("FAIL ecall_accept_busy got=%b exp=1", trap_busy);
        end
        @(posedge clk);
        #1 exc_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if ({flush, csr_we, redirect_valid, trap_busy} !==
                {c == 1, c <= 4, c == 5, c <= 5}) begin
                failures++;
                $display("FAIL ecall_timing c=%0d got=%b exp=%b", c,
                         {flush, csr_we, redirect_valid, trap_busy},
                         {c == 1, c <= 4, c == 5, c <= 5});
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (wr_q.size() + rd_q.size() != 0) begin
            failures++;
            $display("FAIL ecall_drain got=%0d exp=0", wr_q.size() + rd_q.size());
        end
    endtask

    task automatic test_mret();
        csr_mstatus = 32'h1880;
        csr_mepc    = 32'h8000_0104;
        wr_q.push_back({12'h300, 32'h1888});
        rd_q.push_back(32'h8000_0104);
        mret_valid = 1'b1;
        @(posedge clk);
        #1 mret_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({flush, csr_we, redirect_valid, trap_busy} !==
                {c == 1, c == 1, c == 2, c <= 2}) begin
                failures++;
                $display("FAIL mret_timing c=%0d got=%b exp=%b", c,
                         {flush, csr_we, redirect_valid, trap_busy},
                         {c == 1, c == 1, c == 2, c <= 2});
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (wr_q.size() + rd_q.size() != 0) begin
            failures++;
            $display("FAIL mret_drain got=%0d exp=0", wr_q.size() + rd_q.size());
        end
    endtask

    task automatic test_irq();
        csr_mstatus = 32'h8;
        csr_mie     = 32'h80;
        csr_mtvec   = 32'h8000_0001;
        int_pc      = 32'h8000_0200;
        push_trap(32'h8000_0200, 32'h8000_0007, 32'h0, 32'h1880, 32'h8000_001C);
        irq_timer = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            #1;
            // line drops mid-sequence; cause is already captured
            if (c == 2) irq_timer = 1'b0;
            @(negedge clk);
            checks++;
            if ({csr_we, redirect_valid} !== {c <= 4, c == 5}) begin
                failures++;
                $display("FAIL irq_timer_timing c=%0d got=%b exp=%b", c,
                         {csr_we, redirect_valid}, {c <= 4, c == 5});
            end
            @(posedge clk);
        end
        #1;
        // all three pending: MEI wins, vectored to base+44
        csr_mie = 32'h888;
        int_pc  = 32'h8000_0300;
        push_trap(32'h8000_0300, 32'h8000_000B, 32'h0, 32'h1880, 32'h8000_002C);
        {irq_ext, irq_sw, irq_timer} = 3'b111;
        @(posedge clk);
        #1 {irq_ext, irq_sw, irq_timer} = 3'b000;
        repeat (6) @(posedge clk);
        #1;
        // MSI beats MTI
        int_pc = 32'h8000_0400;
        push_trap(32'h8000_0400, 32'h8000_0003, 32'h0, 32'h1880, 32'h8000_000C);
        {irq_sw, irq_timer} = 2'b11;
        @(posedge clk);
        #1 {irq_sw, irq_timer} = 2'b00;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() + rd_q.size() != 0) begin
            failures++;
            $display("FAIL irq_drain got=%0d exp=0", wr_q.size() + rd_q.size());
        end
        csr_mie = 32'h0;
    endtask

    task automatic test_wait_states();
        csr_mstatus = 32'h8;
        csr_mtvec   = 32'h8000_0000;
        push_trap(32'h8000_0500, 32'h2, 32'hDEAD_BEEF, 32'h1880, 32'h8000_0000);
        exc_valid = 1'b1;
        exc_cause = 4'd2;
        exc_pc    = 32'h8000_0500;
        exc_tval  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 exc_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            csr_wack = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                checks++;
                if ({csr_we, csr_waddr, csr_wdata} !== {1'b1, 12'h342, 32'h2}) begin
                    failures++;
                    $display("FAIL wait_hold c=%0d got we=%b addr=%h data=%h exp 1/342/2",
                             c, csr_we, csr_waddr, csr_wdata);
                end
            end
            checks++;
            if ({trap_busy, redirect_valid} !== {c <= 8, c == 8}) begin
                failures++;
                $display("FAIL wait_timing c=%0d got=%b exp=%b", c,
                         {trap_busy, redirect_valid}, {c <= 8, c == 8});
            end
            @(posedge clk);
            #1;
        end
        csr_wack = 1'b1;
        checks++;
        if (wr_q.size() + rd_q.size() != 0) begin
            failures++;
            $display("FAIL wait_drain got=%0d exp=0", wr_q.size() + rd_q.size());
        end
    endtask

    task automatic test_simul_masked();
        csr_mstatus = 32'h8;
        csr_mtvec   = 32'h8000_0000;
        push_trap(32'h8000_0600, 32'h3, 32'h0, 32'h1880, 32'h8000_0000);
        exc_valid  = 1'b1;
        mret_valid = 1'b1;
        exc_cause  = 4'd3;
        exc_pc     = 32'h8000_0600;
        exc_tval   = 32'h0;
        @(posedge clk);
        #1 {exc_valid, mret_valid} = 2'b00;
        @(negedge clk);
        checks++;
        if (csr_waddr !== 12'h341) begin
            failures++;
            $display("FAIL simul_first_addr got=%h exp=341", csr_waddr);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() + rd_q.size() != 0) begin
            failures++;
            $display("FAIL simul_drain got=%0d exp=0", wr_q.size() + rd_q.size());
        end
        csr_mstatus = 32'h0;
        csr_mie     = 32'h80;
        irq_timer   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({csr_we, trap_busy} !== 2'b00) begin
                failures++;
                $display("FAIL masked_irq c=%0d got=%b exp=00", c, {csr_we, trap_busy});
            end
            @(posedge clk);
        end
        #1 irq_timer = 1'b0;
        csr_mie = 32'h0;
    endtask

    task automatic test_reset_midop();
        csr_mstatus = 32'h8;
        csr_mtvec   = 32'h8000_0000;
        push_trap(32'h8000_0700, 32'hB, 32'h0, 32'h1880, 32'h8000_0000);
        exc_valid = 1'b1;
        exc_cause = 4'd11;
        exc_pc    = 32'h8000_0700;
        @(posedge clk);
        #1 exc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({csr_we, csr_waddr} !== {1'b1, 12'h343}) begin
            failures++;
            $display("FAIL midop_in_mtval got we=%b addr=%h exp 1/343", csr_we, csr_waddr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({csr_we, redirect_valid, trap_busy, flush} !== 4'b0) begin
            failures++;
            $display("FAIL midop_reset got=%b exp=0000",
                     {csr_we, redirect_valid, trap_busy, flush});
        end
        wr_q.delete();
        rd_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({csr_we, redirect_valid, flush} !== 3'b000) begin
                failures++;
                $display("FAIL midop_quiet c=%0d got=%b exp=000", c,
                         {csr_we, redirect_valid, flush});
            end
            @(posedge clk);
            #1;
        end
        push_trap(32'h8000_0800, 32'hB, 32'h0, 32'h1880, 32'h8000_0000);
        exc_valid = 1'b1;
        exc_pc    = 32'h8000_0800;
        @(posedge clk);
        #1 exc_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if ({flush, csr_we, redirect_valid} !== {c == 1, c <= 4, c == 5}) begin
                failures++;
                $display("FAIL post_reset_timing c=%0d got=%b exp=%b", c,
                         {flush, csr_we, redirect_valid}, {c == 1, c <= 4, c == 5});
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (wr_q.size() + rd_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_drain got=%0d exp=0", wr_q.size() + rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_ecall();
        test_mret();
        test_irq();
        test_wait_states();
        test_simul_masked();
        test_reset_midop();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
